// File: rtl/lsu_ctrl.sv
// Load/store unit: turns decoded load/store requests into one req/ack data-bus
// transaction, stalling the core until it completes, aborts, or is rejected.
module lsu_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [2:0]  mask,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata_o,
    output logic        access_err,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  mask_q, mask_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] rdata_q, rdata_d;

    logic        op_valid, op_legal, mask_ok, align_ok;
    logic [3:0]  be_new;
    logic [31:0] wdata_new, load_ext;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Legality and lane steering of the incoming request (only used in IDLE).
    always_comb begin
        op_valid = mem_rd | mem_wr;
        mask_ok  = 1'b0;
        if (mem_rd && !mem_wr) begin
            mask_ok = (mask != 3'b011) && (mask != 3'b110) && (mask != 3'b111);
        end else if (mem_wr && !mem_rd) begin
            mask_ok = !mask[2];
        end
        case (mask[1:0])
            2'b01:   align_ok = !addr[0];
            2'b10:   align_ok = (addr[1:0] == 2'b00);
            default: align_ok = 1'b1;
        endcase
        op_legal = op_valid && mask_ok && align_ok;

        case (mask[1:0])
            2'b00: begin
                be_new    = 4'b0001 << addr[1:0];
                wdata_new = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_new    = 4'b0011 << addr[1:0];
                wdata_new = {2{wdata[15:0]}};
            end
            default: begin
                be_new    = 4'b1111;
                wdata_new = wdata;
            end
        endcase
    end

    // Load alignment and extension from the word returned by the bus.
    always_comb begin
        ld_byte = dbus_rdata[{off_q, 3'b000} +: 8];
        ld_half = dbus_rdata[{off_q[1], 4'b0000} +: 16];
        case (mask_q)
            3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  load_ext = {24'b0, ld_byte};
            3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
            3'b101:  load_ext = {16'b0, ld_half};
            default: load_ext = dbus_rdata;
        endcase
    end

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        mask_d     = mask_q;
        off_d      = off_q;
        rdata_d    = rdata_q;
        stall      = 1'b0;
        access_err = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    if (op_legal) begin
                        stall   = 1'b1;
                        state_d = S_BUSY;
                        cnt_d   = 8'd0;
                        err_d   = 1'b0;
                        we_d    = mem_wr;
                        addr_d  = {addr[31:2], 2'b00};
                        be_d    = be_new;
                        wdata_d = wdata_new;
                        mask_d  = mask;
                        off_d   = addr[1:0];
                    end else begin
                        access_err = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                stall = 1'b1;
                if (dbus_ack) begin
                    state_d = S_DONE;
                    err_d   = 1'b0;
                    rdata_d = we_q ? 32'd0 : load_ext;
                end else if (cnt_q == CNT_LAST) begin
                    // Ack in the last allowed cycle is handled above and wins.
                    state_d = S_DONE;
                    err_d   = 1'b1;
                    rdata_d = 32'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                access_err = err_q;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (rst) begin
            stall      = 1'b0;
            access_err = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            mask_q  <= 3'd0;
            off_q   <= 2'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            off_q   <= off_d;
            rdata_q <= rdata_d;
        end
    end

    assign dbus_req   = (state_q == S_BUSY);
    assign dbus_we    = we_q;
    assign dbus_addr  = addr_q;
    assign dbus_be    = be_q;
    assign dbus_wdata = wdata_q;
    assign rdata_o    = rdata_q;

endmodule
